// File: rtl/alu_op_reg_pipe.sv
// Registered, handshaked RV R-type execute unit with an output hold register and flush.
// Define ALU_MEXT_EN to add MUL*/DIV*/REM* (multiplier plus an iterative restoring divider).
module alu_op_reg_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_value,
    output logic            out_illegal
);
    localparam int SHW = $clog2(XLEN);

`ifdef ALU_MEXT_EN
    typedef enum logic [0:0] {IDLE, DIV} state_t;
`else
    typedef enum logic [0:0] {IDLE} state_t;
`endif
    state_t state;

    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] res;
    logic            illegal;
    logic            is_div;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign shamt    = rs2[SHW-1:0];

`ifdef ALU_MEXT_EN
    localparam int CW = $clog2(XLEN + 1);

    // Operands widened by one bit so one signed multiply covers MULH, MULHSU and MULHU.
    logic signed [XLEN:0]     mul_a, mul_b;
    logic signed [2*XLEN+1:0] prod;
    assign mul_a = {(funct3 == 3'd1 || funct3 == 3'd2) ? rs1[XLEN-1] : 1'b0, rs1};
    assign mul_b = {(funct3 == 3'd1) ? rs2[XLEN-1] : 1'b0, rs2};
    assign prod  = mul_a * mul_b;

    logic [XLEN-1:0] div_quo, div_rem, div_dvs;
    logic [CW-1:0]   div_cnt;
    logic            div_neg_q, div_neg_r, div_is_rem;
    logic [XLEN:0]   rem_sh, diff;
    logic            a_neg, b_neg;

    assign rem_sh = {div_rem, div_quo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, div_dvs};
    assign a_neg  = !funct3[0] && rs1[XLEN-1];
    assign b_neg  = !funct3[0] && rs2[XLEN-1];
`endif

    always_comb begin
        res     = '0;
        illegal = 1'b0;
        is_div  = 1'b0;
        case (funct7)
            7'b0000000: begin
                case (funct3)
                    3'd0: res = rs1 + rs2;
                    3'd1: res = rs1 << shamt;
                    3'd2: res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
                    3'd3: res = {{(XLEN-1){1'b0}}, rs1 < rs2};
                    3'd4: res = rs1 ^ rs2;
                    3'd5: res = rs1 >> shamt;
                    3'd6: res = rs1 | rs2;
                    default: res = rs1 & rs2;
                endcase
            end
            7'b0100000: begin
                case (funct3)
                    3'd0: res = rs1 - rs2;
                    3'd5: res = $signed(rs1) >>> shamt;
                    default: illegal = 1'b1;
                endcase
            end
`ifdef ALU_MEXT_EN
            7'b0000001: begin
                if (funct3[2])
                    is_div = 1'b1;
                else if (funct3 == 3'd0)
                    res = prod[XLEN-1:0];
                else
                    res = prod[2*XLEN-1:XLEN];
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_value   <= '0;
            out_illegal <= 1'b0;
`ifdef ALU_MEXT_EN
            div_quo     <= '0;
            div_rem     <= '0;
            div_dvs     <= '0;
            div_cnt     <= '0;
            div_neg_q   <= 1'b0;
            div_neg_r   <= 1'b0;
            div_is_rem  <= 1'b0;
`endif
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept && !is_div) begin
                out_valid   <= 1'b1;
                out_value   <= illegal ? '0 : res;
                out_illegal <= illegal;
            end
`ifdef ALU_MEXT_EN
            // Magnitudes go in up front; a zero divisor keeps the all-ones quotient unsigned.
            if (accept && is_div) begin
                state      <= DIV;
                div_quo    <= a_neg ? -rs1 : rs1;
                div_dvs    <= b_neg ? -rs2 : rs2;
                div_rem    <= '0;
                div_cnt    <= '0;
                div_neg_q  <= (a_neg ^ b_neg) && (rs2 != '0);
                div_neg_r  <= a_neg;
                div_is_rem <= funct3[1];
            end
            if (state == DIV) begin
                if (div_cnt != CW'(XLEN)) begin
                    div_rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                    div_quo <= {div_quo[XLEN-2:0], !diff[XLEN]};
                    div_cnt <= div_cnt + 1'b1;
                end else begin
                    state       <= IDLE;
                    out_valid   <= 1'b1;
                    out_illegal <= 1'b0;
                    if (div_is_rem)
                        out_value <= div_neg_r ? -div_rem : div_rem;
                    else
                        out_value <= div_neg_q ? -div_quo : div_quo;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_op_reg_pipe.sv
// Directed bench for alu_op_reg_pipe: XLEN=32 main instance plus an XLEN=64 instance for wide shifts.
module tb_alu_op_reg_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, out_value;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_illegal;
    logic [6:0]  w_funct7;
    logic [2:0]  w_funct3;
    logic [63:0] w_rs1, w_rs2, w_out_value;

    int checks = 0;
    int failures = 0;

    alu_op_reg_pipe #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .funct7(funct7), .funct3(funct3), .rs1(rs1), .rs2(rs2), .out_valid(out_valid),
        .out_ready(out_ready), .out_value(out_value), .out_illegal(out_illegal)
    );

    alu_op_reg_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .funct7(w_funct7), .funct3(w_funct3), .rs1(w_rs1), .rs2(w_rs2), .out_valid(w_out_valid),
        .out_ready(1'b1), .out_value(w_out_value), .out_illegal(w_out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one op at a negedge and drop in_valid just after the accepting edge.
    task automatic drive(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct7 = f7; funct3 = f3; rs1 = a; rs2 = b; in_valid = 1'b1;
        chk({tag, "_rdy"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic alu(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic ill);
        drive(tag, f7, f3, a, b);
        @(negedge clk);
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_val"}, out_value, exp);
        chk({tag, "_ill"}, out_illegal, ill);
    endtask

`ifdef ALU_MEXT_EN
    task automatic divop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int n;
        drive(tag, 7'b0000001, f3, a, b);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        chk({tag, "_lat"}, n, 33);
        chk({tag, "_val"}, out_value, exp);
    endtask
`endif

    initial begin
        flush = 0; in_valid = 0; out_ready = 1; funct7 = 0; funct3 = 0; rs1 = 0; rs2 = 0;
        w_in_valid = 0; w_funct7 = 0; w_funct3 = 0; w_rs1 = 0; w_rs2 = 0;
        repeat (2) @(negedge clk);
        chk("rst_vld", out_valid, 0);
        chk("rst_val", out_value, 0);
        chk("rst_ill", out_illegal, 0);
        rst_n = 1'b1;
        #1 chk("rst_rdy", in_ready, 1);

        alu("add_wrap", 7'b0000000, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 0);
        alu("sub_wrap", 7'b0100000, 3'd0, 32'h0, 32'd1, 32'hFFFF_FFFF, 0);
        alu("sra",      7'b0100000, 3'd5, 32'h8000_0000, 32'h24, 32'hF800_0000, 0);
        alu("srl",      7'b0000000, 3'd5, 32'h8000_0000, 32'h24, 32'h0800_0000, 0);
        alu("slt",      7'b0000000, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
        alu("sltu",     7'b0000000, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        alu("and",      7'b0000000, 3'd7, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0);
        alu("ill_f3",   7'b0100000, 3'd4, 32'h1234, 32'h5678, 32'h0, 1);
`ifndef ALU_MEXT_EN
        alu("ill_m",    7'b0000001, 3'd0, 32'd3, 32'd4, 32'h0, 1);
`endif

        // 64-bit shift on the wide instance
        @(negedge clk);
        w_funct7 = 7'b0000000; w_funct3 = 3'd1; w_rs1 = 64'd1; w_rs2 = 64'd63; w_in_valid = 1'b1;
        @(posedge clk);
        #1 w_in_valid = 1'b0;
        @(negedge clk);
        chk("sll64_vld", w_out_valid, 1);
        chk("sll64_val", w_out_value, 64'h8000_0000_0000_0000);

        // Backpressure: result held, then three back-to-back ops
        @(negedge clk);
        out_ready = 1'b0;
        drive("bp_add", 7'b0000000, 3'd0, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_vld", out_valid, 1);
            chk("bp_hold_val", out_value, 32'd7);
            chk("bp_hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        funct7 = 7'b0000000; funct3 = 3'd0; rs1 = 32'd10; rs2 = 32'd1; in_valid = 1'b1;
        #1 chk("b2b_rdy", in_ready, 1);
        @(negedge clk);
        chk("b2b0_vld", out_valid, 1);
        chk("b2b0_val", out_value, 32'd11);
        funct3 = 3'd4; rs1 = 32'hF0; rs2 = 32'hFF;
        @(negedge clk);
        chk("b2b1_vld", out_valid, 1);
        chk("b2b1_val", out_value, 32'h0F);
        funct3 = 3'd6; rs1 = 32'h100; rs2 = 32'h001;
        @(negedge clk);
        chk("b2b2_vld", out_valid, 1);
        chk("b2b2_val", out_value, 32'h101);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drain", out_valid, 0);

        // Flush drops a held result and blocks a same-cycle accept
        out_ready = 1'b0;
        drive("fl_add", 7'b0000000, 3'd0, 32'd5, 32'd6);
        @(negedge clk);
        out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; funct3 = 3'd0;
        #1 chk("fl_rdy_blk", in_ready, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1 chk("fl_vld", out_valid, 0);
        chk("fl_rdy", in_ready, 1);
        @(negedge clk);
        chk("fl_noacc", out_valid, 0);

        // Async reset clears a held result immediately
        out_ready = 1'b0;
        drive("rs_add", 7'b0000000, 3'd0, 32'd1, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rs_vld", out_valid, 0);
        chk("rs_val", out_value, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;

`ifdef ALU_MEXT_EN
        alu("mulh", 7'b0000001, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        alu("mul",  7'b0000001, 3'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 0);
        alu("mulhu", 7'b0000001, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        divop("div_neg",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        divop("rem_neg",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        divop("divu_z",   3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        divop("rem_z",    3'd6, 32'd5, 32'd0, 32'd5);
        divop("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        divop("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        divop("divu",     3'd5, 32'd100, 32'd7, 32'd14);

        drive("dfl", 7'b0000001, 3'd4, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        chk("dfl_busy", in_ready, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1 chk("dfl_vld", out_valid, 0);
        chk("dfl_rdy", in_ready, 1);
        repeat (30) @(negedge clk);
        chk("dfl_stale", out_valid, 0);

        drive("drs", 7'b0000001, 3'd4, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("drs_vld", out_valid, 0);
        chk("drs_rdy", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("drs_stale", out_valid, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
